slap_palette_mixer: RTL and testbench

Final video stage downstream of the sprite layer: takes the sprite line-buffer pixel byte (`SPR_PIX`), the background tile pixel and the foreground character pixel. It resolves priority between them, looks the winner up in a CPU-writable 1024-entry RGB444 palette, and drives registered RGB with aligned blanking. After reset, a clear engine zeroes the whole palette. While the clear runs, CPU writes are held in a one-deep pending slot.

---
 rtl/slap_palette_mixer_pkg.sv | 53 +++++
 rtl/slap_palette_mixer_if.sv | 21 ++
 rtl/slap_palette_mixer_pal_ram.sv | 49 ++++
 rtl/slap_palette_mixer.sv | 151 +++++++++++++++
 tb/tb_slap_palette_mixer.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/slap_palette_mixer_pkg.sv
// Shared video definitions: palette regions, layer-enable bits, clear FSM states
// and the palette write-port bundle used by the mixer.
package slap_video_pkg;

    localparam int unsigned PAL_ENTRIES = 1024;
    localparam int unsigned PAL_AW      = 10;

    localparam logic [PAL_AW-1:0] PAL_FG_BASE  = 10'h000;
    localparam logic [PAL_AW-1:0] PAL_SPR_BASE = 10'h100;
    localparam logic [PAL_AW-1:0] PAL_BG_BASE  = 10'h200;

    localparam int unsigned LAYER_BG  = 0;
    localparam int unsigned LAYER_SPR = 1;
    localparam int unsigned LAYER_FG  = 2;

    typedef enum logic [1:0] {
        CLR_CLEAR = 2'd0,
        CLR_DRAIN = 2'd1,
        CLR_IDLE  = 2'd2
    } clr_state_e;

    typedef struct packed {
        logic              we;
        logic [1:0]        be;
        logic [PAL_AW-1:0] addr;
        logic [11:0]       data;
    } pal_wr_t;

    // Byte 0 lands in bits [7:0] ({G,R}); byte 1 keeps only its low nibble (B).
    function automatic pal_wr_t pal_cpu_wr(input logic [10:0] addr, input logic [7:0] din);
        pal_wr_t w;
        w.we   = 1'b1;
        w.be   = addr[0] ? 2'b10 : 2'b01;
        w.addr = addr[10:1];
        w.data = {din[3:0], din};
        return w;
    endfunction

    // Transparency is judged on the pixel code only; enabled BG is always opaque.
    function automatic logic [PAL_AW-1:0] pal_index(input logic [5:0] fg, input logic [7:0] spr,
                                                    input logic [7:0] bg, input logic [2:0] en);
        logic [PAL_AW-1:0] idx;
        idx = '0;
        if (en[LAYER_FG] && (fg[1:0] != 2'b00))
            idx = PAL_FG_BASE | {4'b0000, fg};
        else if (en[LAYER_SPR] && (spr[3:0] != 4'h0))
            idx = PAL_SPR_BASE | {2'b00, spr};
        else if (en[LAYER_BG])
            idx = PAL_BG_BASE | {2'b00, bg};
        return idx;
    endfunction

endpackage

// File: rtl/slap_palette_mixer_if.sv
// CPU palette bus: byte address, write data, active-low selects, read data and busy.
interface slap_palette_mixer_if;

    logic [10:0] CPU_ADDR;
    logic [7:0]  CPU_DIN;
    logic        PAL_CS;
    logic        Z80_WR;
    logic [7:0]  PAL_DOUT;
    logic        PAL_BUSY;

    modport master (
        output CPU_ADDR, CPU_DIN, PAL_CS, Z80_WR,
        input  PAL_DOUT, PAL_BUSY
    );

    modport slave (
        input  CPU_ADDR, CPU_DIN, PAL_CS, Z80_WR,
        output PAL_DOUT, PAL_BUSY
    );

endinterface

// File: rtl/slap_palette_mixer_pal_ram.sv
// 1024 x 12 palette RAM: port A writes with byte enables and reads for the CPU,
// port B is the video read. Both reads are registered and return pre-write data.
module slap_pal_ram
    import slap_video_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              a_we_i,
    input  logic [1:0]        a_be_i,
    input  logic [PAL_AW-1:0] a_waddr_i,
    input  logic [11:0]       a_wdata_i,
    input  logic [PAL_AW-1:0] a_raddr_i,
    output logic [11:0]       a_rdata_o,
    input  logic              b_en_i,
    input  logic [PAL_AW-1:0] b_addr_i,
    output logic [11:0]       b_rdata_o
);

    logic [11:0] mem_q [PAL_ENTRIES];
    logic [11:0] a_rdata_q;
    logic [11:0] b_rdata_q;

    always_ff @(posedge clk_i) begin
        if (a_we_i) begin
            if (a_be_i[0]) mem_q[a_waddr_i][7:0]  <= a_wdata_i[7:0];
            if (a_be_i[1]) mem_q[a_waddr_i][11:8] <= a_wdata_i[11:8];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_rdata_q <= '0;
        end else begin
            a_rdata_q <= mem_q[a_raddr_i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            b_rdata_q <= '0;
        end else if (b_en_i) begin
            b_rdata_q <= mem_q[b_addr_i];
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/slap_palette_mixer.sv
// Final video stage: layer priority, palette lookup and registered RGB with aligned
// blanking. After reset the palette is zeroed; CPU writes meanwhile wait in a one-deep slot.
module slap_palette_mixer
    import slap_video_pkg::*;
#(
    parameter int unsigned PIPE_LAT = 3,
    parameter int unsigned CLR_LEN  = PAL_ENTRIES
) (
    input  logic                master_clk,
    input  logic                reset,
    input  logic                pix_ce,
    input  logic [7:0]          SPR_PIX,
    input  logic [7:0]          BG_PIX,
    input  logic [5:0]          FG_PIX,
    input  logic [2:0]          LAYER_EN,
    input  logic                HBLANK,
    input  logic                VBLANK,
    slap_palette_mixer_if.slave cpu,
    output logic [3:0]          RED,
    output logic [3:0]          GREEN,
    output logic [3:0]          BLUE,
    output logic                HBLANK_O,
    output logic                VBLANK_O
);

    localparam logic [PAL_AW-1:0] CLR_LAST = 10'(CLR_LEN - 1);

    clr_state_e        state_q, state_d;
    logic [PAL_AW-1:0] clr_cnt_q, clr_cnt_d;
    logic              pend_vld_q, pend_vld_d;
    logic [10:0]       pend_addr_q, pend_addr_d;
    logic [7:0]        pend_data_q, pend_data_d;
    logic              req_q;
    logic              req_now;
    logic              wr_req;
    pal_wr_t           wr_d;
    logic              rd_hi_q;
    logic [11:0]       a_rdata;

    logic [PAL_AW-1:0] idx_q;
    logic [11:0]       b_rdata;
    logic [PIPE_LAT-1:0] hb_q;
    logic [PIPE_LAT-1:0] vb_q;
    logic [11:0]       rgb_q;

    // A request held over many cycles yields a single write on its rising edge.
    assign req_now = ~cpu.PAL_CS & ~cpu.Z80_WR;
    assign wr_req  = req_now & ~req_q;

    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            state_q     <= CLR_CLEAR;
            clr_cnt_q   <= '0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            req_q       <= 1'b0;
            rd_hi_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            req_q       <= req_now;
            rd_hi_q     <= cpu.CPU_ADDR[0];
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        wr_d        = '0;
        unique case (state_q)
            CLR_CLEAR: begin
                wr_d.we   = 1'b1;
                wr_d.be   = 2'b11;
                wr_d.addr = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + 10'd1;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d   = CLR_DRAIN;
                    clr_cnt_d = '0;
                end
                if (wr_req) begin
                    pend_vld_d  = 1'b1;
                    pend_addr_d = cpu.CPU_ADDR;
                    pend_data_d = cpu.CPU_DIN;
                end
            end
            CLR_DRAIN: begin
                // A request landing on the drain edge supersedes the slot (last wins).
                if (wr_req)
                    wr_d = pal_cpu_wr(cpu.CPU_ADDR, cpu.CPU_DIN);
                else if (pend_vld_q)
                    wr_d = pal_cpu_wr(pend_addr_q, pend_data_q);
                pend_vld_d = 1'b0;
                state_d    = CLR_IDLE;
            end
            CLR_IDLE: begin
                if (wr_req)
                    wr_d = pal_cpu_wr(cpu.CPU_ADDR, cpu.CPU_DIN);
            end
            default: state_d = CLR_CLEAR;
        endcase
    end

    slap_pal_ram u_ram (
        .clk_i     (master_clk),
        .rst_i     (reset),
        .a_we_i    (wr_d.we),
        .a_be_i    (wr_d.be),
        .a_waddr_i (wr_d.addr),
        .a_wdata_i (wr_d.data),
        .a_raddr_i (cpu.CPU_ADDR[10:1]),
        .a_rdata_o (a_rdata),
        .b_en_i    (pix_ce),
        .b_addr_i  (idx_q),
        .b_rdata_o (b_rdata)
    );

    assign cpu.PAL_DOUT = rd_hi_q ? {4'h0, a_rdata[11:8]} : a_rdata[7:0];
    assign cpu.PAL_BUSY = (state_q != CLR_IDLE);

    // S1 index, S2 palette read (inside the RAM), S3 RGB; blanking rides alongside.
    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            hb_q  <= '1;
            vb_q  <= '1;
            rgb_q <= '0;
        end else if (pix_ce) begin
            idx_q <= pal_index(FG_PIX, SPR_PIX, BG_PIX, LAYER_EN);
            hb_q  <= {hb_q[PIPE_LAT-2:0], HBLANK};
            vb_q  <= {vb_q[PIPE_LAT-2:0], VBLANK};
            if (hb_q[PIPE_LAT-2] || vb_q[PIPE_LAT-2])
                rgb_q <= '0;
            else
                rgb_q <= {b_rdata[3:0], b_rdata[7:4], b_rdata[11:8]};
        end
    end

    assign RED      = rgb_q[11:8];
    assign GREEN    = rgb_q[7:4];
    assign BLUE     = rgb_q[3:0];
    assign HBLANK_O = hb_q[PIPE_LAT-1];
    assign VBLANK_O = vb_q[PIPE_LAT-1];

endmodule

// File: tb/tb_slap_palette_mixer.sv
// Self-checking bench for slap_palette_mixer: palette clear, pending writes, priority,
// blanking, pixel-enable hold, write strobe and read/write collision.
module tb_slap_palette_mixer;

    logic        master_clk = 1'b0;
    logic        reset;
    logic        pix_ce;
    logic [7:0]  SPR_PIX, BG_PIX;
    logic [5:0]  FG_PIX;
    logic [2:0]  LAYER_EN;
    logic        HBLANK, VBLANK;
    logic [3:0]  RED, GREEN, BLUE;
    logic        HBLANK_O, VBLANK_O;

    slap_palette_mixer_if cpu_if ();

    slap_palette_mixer dut (
        .master_clk (master_clk),
        .reset      (reset),
        .pix_ce     (pix_ce),
        .SPR_PIX    (SPR_PIX),
        .BG_PIX     (BG_PIX),
        .FG_PIX     (FG_PIX),
        .LAYER_EN   (LAYER_EN),
        .HBLANK     (HBLANK),
        .VBLANK     (VBLANK),
        .cpu        (cpu_if.slave),
        .RED        (RED),
        .GREEN      (GREEN),
        .BLUE       (BLUE),
        .HBLANK_O   (HBLANK_O),
        .VBLANK_O   (VBLANK_O)
    );

    always #5 master_clk = ~master_clk;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hb;
        logic        vb;
    } vout_t;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned edge_n = 0;
    logic [7:0]  b0_m [1024];
    logic [3:0]  b1_m [1024];
    vout_t       hist [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge master_clk);
        #1;
        edge_n++;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) begin
            b0_m[i] = 8'h00;
            b1_m[i] = 4'h0;
        end
    endtask

    task automatic model_wr(input logic [10:0] a, input logic [7:0] d);
        if (a[0]) b1_m[a[10:1]] = d[3:0];
        else      b0_m[a[10:1]] = d;
    endtask

    task automatic cpu_req(input logic [10:0] a, input logic [7:0] d);
        cpu_if.CPU_ADDR = a;
        cpu_if.CPU_DIN  = d;
        cpu_if.PAL_CS   = 1'b0;
        cpu_if.Z80_WR   = 1'b0;
    endtask

    task automatic cpu_rel();
        cpu_if.PAL_CS = 1'b1;
        cpu_if.Z80_WR = 1'b1;
    endtask

    task automatic cpu_wr(input logic [10:0] a, input logic [7:0] d);
        cpu_req(a, d);
        tick();
        cpu_rel();
        tick();
        model_wr(a, d);
    endtask

    task automatic rd(input logic [10:0] a, output logic [7:0] d);
        cpu_if.CPU_ADDR = a;
        tick();
        d = cpu_if.PAL_DOUT;
    endtask

    // Busy must hold through edge 1024 and be gone after edge 1025.
    task automatic finish_clear(input string tag);
        while (edge_n < 1024) tick();
        chk({tag, "_busy_1024"}, 32'(cpu_if.PAL_BUSY), 32'd1);
        tick();
        chk({tag, "_busy_1025"}, 32'(cpu_if.PAL_BUSY), 32'd0);
    endtask

    function automatic vout_t expect_px(input logic [5:0] fg, input logic [7:0] spr,
                                        input logic [7:0] bg, input logic [2:0] en,
                                        input logic hb, input logic vb);
        int    idx;
        vout_t v;
        if (en[2] && (fg % 4) != 0)        idx = int'(fg);
        else if (en[1] && (spr % 16) != 0) idx = 256 + int'(spr);
        else if (en[0])                    idx = 512 + int'(bg);
        else                               idx = 0;
        v.rgb = {b0_m[idx][3:0], b0_m[idx][7:4], b1_m[idx]};
        if (hb || vb) v.rgb = 12'h000;
        v.hb = hb;
        v.vb = vb;
        return v;
    endfunction

    // Output after the k-th accepted pixel equals the pixel accepted at k-2.
    task automatic push(input logic [5:0] fg, input logic [7:0] spr, input logic [7:0] bg,
                        input logic [2:0] en, input logic hb, input logic vb, input logic ce);
        vout_t e;
        FG_PIX   = fg;
        SPR_PIX  = spr;
        BG_PIX   = bg;
        LAYER_EN = en;
        HBLANK   = hb;
        VBLANK   = vb;
        pix_ce   = ce;
        if (ce) hist.push_back(expect_px(fg, spr, bg, en, hb, vb));
        tick();
        if (hist.size() >= 3) e = hist[hist.size() - 3];
        else                  e = '{rgb: 12'h000, hb: 1'b1, vb: 1'b1};
        chk("video", 32'({RED, GREEN, BLUE, HBLANK_O, VBLANK_O}), 32'(e));
        pix_ce = 1'b0;
    endtask

    initial begin
        logic [7:0] d, d1, d2, old_b0;

        reset = 1'b1;
        pix_ce = 1'b0;
        FG_PIX = '0; SPR_PIX = '0; BG_PIX = '0; LAYER_EN = '0;
        HBLANK = 1'b0; VBLANK = 1'b0;
        cpu_if.CPU_ADDR = '0;
        cpu_if.CPU_DIN  = '0;
        cpu_rel();

        // Reset values and first clear with one pending write at edge 10
        repeat (5) tick();
        chk("rst_rgb", 32'({RED, GREEN, BLUE}), 32'h000);
        chk("rst_hblank_o", 32'(HBLANK_O), 32'd1);
        chk("rst_vblank_o", 32'(VBLANK_O), 32'd1);
        chk("rst_busy", 32'(cpu_if.PAL_BUSY), 32'd1);
        chk("rst_dout", 32'(cpu_if.PAL_DOUT), 32'h00);
        reset = 1'b0;
        edge_n = 0;
        repeat (9) tick();
        cpu_req({10'h105, 1'b0}, 8'hA5);
        tick();
        tick();
        cpu_rel();
        finish_clear("clr1");
        model_clear();
        model_wr({10'h105, 1'b0}, 8'hA5);
        for (int e = 0; e < 1024; e++) begin
            for (int b = 0; b < 2; b++) begin
                rd({10'(e), 1'(b)}, d);
                chk("clear_read", 32'(d), b == 0 ? 32'(b0_m[e]) : 32'(b1_m[e]));
            end
        end

        // Reset mid-clear discards the pending write and restarts from entry 0
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        edge_n = 0;
        repeat (9) tick();
        cpu_req({10'h2FF, 1'b0}, 8'h77);
        tick();
        cpu_rel();
        while (edge_n < 100) tick();
        reset = 1'b1;
        #1;
        chk("midclr_rst_busy", 32'(cpu_if.PAL_BUSY), 32'd1);
        repeat (3) tick();
        reset = 1'b0;
        edge_n = 0;
        finish_clear("clr2");
        model_clear();
        rd({10'h2FF, 1'b0}, d);
        chk("discarded_pending", 32'(d), 32'h00);

        // Two busy writes to the same byte: the later one wins
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        edge_n = 0;
        repeat (9) tick();
        cpu_req({10'h105, 1'b0}, 8'hA5);
        tick();
        cpu_rel();
        while (edge_n < 19) tick();
        cpu_req({10'h105, 1'b0}, 8'h3C);
        tick();
        cpu_rel();
        finish_clear("clr3");
        model_clear();
        rd({10'h105, 1'b0}, d);
        chk("pending_last_wins", 32'(d), 32'h3C);
        rd({10'h105, 1'b1}, d);
        chk("pending_b1_untouched", 32'(d), 32'h00);

        // Held strobe with data changing mid-strobe stores first-cycle data only
        d1 = 8'($urandom);
        d2 = d1 ^ 8'h5A;
        cpu_req({10'h3A5, 1'b0}, d1);
        repeat (3) tick();
        cpu_if.CPU_DIN = d2;
        repeat (3) tick();
        cpu_rel();
        tick();
        model_wr({10'h3A5, 1'b0}, d1);
        rd({10'h3A5, 1'b0}, d);
        chk("strobe_first_data", 32'(d), 32'(b0_m[10'h3A5]));
        d = 8'($urandom) | 8'hF0;
        cpu_wr({10'h3A5, 1'b1}, d);
        rd({10'h3A5, 1'b1}, d1);
        chk("byte1_upper_zero", 32'(d1), 32'({4'h0, d[3:0]}));

        // Random fill of the video regions, then the directed entries
        for (int e = 0; e < 1024; e++) begin
            if (e < 64 || (e >= 256 && e < 768)) begin
                cpu_wr({10'(e), 1'b0}, 8'($urandom));
                cpu_wr({10'(e), 1'b1}, 8'($urandom));
            end
        end
        cpu_wr({10'h013, 1'b0}, 8'h21); cpu_wr({10'h013, 1'b1}, 8'h03);
        cpu_wr({10'h1F2, 1'b0}, 8'h54); cpu_wr({10'h1F2, 1'b1}, 8'h06);
        cpu_wr({10'h2A7, 1'b0}, 8'h87); cpu_wr({10'h2A7, 1'b1}, 8'h09);
        cpu_wr({10'h000, 1'b0}, 8'hED); cpu_wr({10'h000, 1'b1}, 8'h0F);

        // Priority, exact latency, blanking and enable hold
        push(6'h13, 8'hF2, 8'hA7, 3'b111, 1'b0, 1'b0, 1'b1);
        push(6'h00, 8'hF2, 8'hA7, 3'b111, 1'b0, 1'b0, 1'b1);
        push(6'h00, 8'hF0, 8'hA7, 3'b111, 1'b0, 1'b0, 1'b1);
        chk("prio_fg", 32'({RED, GREEN, BLUE}), 32'h123);
        push(6'h13, 8'hF2, 8'hA7, 3'b000, 1'b0, 1'b0, 1'b1);
        chk("prio_spr", 32'({RED, GREEN, BLUE}), 32'h456);
        push(6'h13, 8'hF2, 8'hA7, 3'b111, 1'b1, 1'b0, 1'b1);
        chk("prio_bg", 32'({RED, GREEN, BLUE}), 32'h789);
        push(6'h13, 8'hF2, 8'hA7, 3'b111, 1'b0, 1'b0, 1'b1);
        chk("prio_none", 32'({RED, GREEN, BLUE}), 32'hDEF);
        chk("hblank_o_low", 32'(HBLANK_O), 32'd0);
        push(6'h00, 8'hF2, 8'hA7, 3'b111, 1'b0, 1'b0, 1'b1);
        chk("hblank_rgb", 32'({RED, GREEN, BLUE}), 32'h000);
        chk("hblank_o_high", 32'(HBLANK_O), 32'd1);
        push(6'h13, 8'hF2, 8'hA7, 3'b111, 1'b0, 1'b0, 1'b1);
        chk("after_blank", 32'({RED, GREEN, BLUE, HBLANK_O}), 32'({12'h123, 1'b0}));
        for (int i = 0; i < 4; i++)
            push(6'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), 1'b0, 1'b0, 1'b0);
        chk("ce_hold", 32'({RED, GREEN, BLUE}), 32'h123);
        push(6'h13, 8'hF2, 8'hA7, 3'b111, 1'b0, 1'b0, 1'b1);
        chk("ce_resume", 32'({RED, GREEN, BLUE}), 32'h456);

        // Randomised pixel stream
        for (int i = 0; i < 300; i++) begin
            push(($urandom_range(3) == 0) ? 6'h00 : 6'($urandom),
                 ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom),
                 8'($urandom), 3'($urandom),
                 ($urandom_range(9) == 0), ($urandom_range(11) == 0),
                 ($urandom_range(3) != 0));
        end

        // Collision: video read and CPU write of entry 0x200 on the same edge
        old_b0 = b0_m[10'h200];
        push(6'h00, 8'h00, 8'h00, 3'b001, 1'b0, 1'b0, 1'b1);
        cpu_req({10'h200, 1'b0}, old_b0 ^ 8'hFF);
        model_wr({10'h200, 1'b0}, old_b0 ^ 8'hFF);
        push(6'h00, 8'h00, 8'h00, 3'b001, 1'b0, 1'b0, 1'b1);
        cpu_rel();
        push(6'h00, 8'h00, 8'h00, 3'b001, 1'b0, 1'b0, 1'b1);
        chk("collision_old", 32'({RED, GREEN}), 32'({old_b0[3:0], old_b0[7:4]}));
        push(6'h00, 8'h00, 8'h00, 3'b001, 1'b0, 1'b0, 1'b1);
        chk("collision_new", 32'({RED, GREEN}), 32'({~old_b0[3:0], ~old_b0[7:4]}));
        push(6'h00, 8'h00, 8'h00, 3'b001, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
